// File: rtl/riscv_boot_pkg.sv
// Shared types for the boot controller: FSM states, byte-count type, output bundle.
// Each state maps to one fixed output vector, so outputs can be registered alongside the state.
package riscv_boot_pkg;

  localparam int TIMEOUT_CYCLES_DEF = 1024;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WRITE,
    ST_RUN,
    ST_ERROR
  } boot_state_e;

  typedef logic [1:0] byte_cnt_t;

  localparam byte_cnt_t BYTE_CNT_LAST = 2'd3;

  typedef struct packed {
    logic core_rst;
    logic done;
    logic err;
    logic busy;
    logic byte_ready;
    logic imem_we;
  } boot_outs_t;

  // Output vector presented while the FSM sits in state s.
  function automatic boot_outs_t state_outs(boot_state_e s);
    boot_outs_t o;
    o          = '0;
    o.core_rst = 1'b1;
    case (s)
      ST_LOAD: begin
        o.busy       = 1'b1;
        o.byte_ready = 1'b1;
      end
      ST_WRITE: begin
        o.busy    = 1'b1;
        o.imem_we = 1'b1;
      end
      ST_RUN: begin
        o.core_rst = 1'b0;
        o.done     = 1'b1;
      end
      ST_ERROR: o.err = 1'b1;
      default:  ;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/boot_word_packer.sv
// Packs accepted bytes little-endian into a word: the first byte lands in [7:0].
// clear_i discards a partial word (new load or timeout).
module boot_word_packer
  import riscv_boot_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clear_i,
  input  logic          accept_i,
  input  logic [7:0]    byte_i,
  output logic [DW-1:0] word_o,
  output logic          last_byte_o
);

  byte_cnt_t     byte_cnt;
  logic [DW-1:0] word_q;

  // NOTE: sequential state is written with <= only, so every register samples
  // pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      byte_cnt <= '0;
      word_q   <= '0;
    end else if (clear_i) begin
      byte_cnt <= '0;
      word_q   <= '0;
    end else if (accept_i) begin
      byte_cnt <= byte_cnt + byte_cnt_t'(1);
      word_q   <= {byte_i, word_q[DW-1:8]};
    end
  end

  assign word_o      = word_q;
  assign last_byte_o = (byte_cnt == BYTE_CNT_LAST);

endmodule

// File: rtl/riscv_boot_ctrl.sv
// Boot controller: streams an image into instruction memory, then releases core reset.
// Outputs are registered together with the state they belong to.
module riscv_boot_ctrl
  import riscv_boot_pkg::*;
#(
  parameter int DW             = 32,
  parameter int NO_OF_REGS     = 256,
  parameter int AW             = $clog2(NO_OF_REGS),
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          start_i,
  input  logic [AW:0]   len_i,
  input  logic          byte_valid_i,
  input  logic [7:0]    byte_i,
  output logic          byte_ready_o,
  output logic          imem_we_o,
  output logic [AW-1:0] imem_addr_o,
  output logic [DW-1:0] imem_wdata_o,
  output logic          core_rst_o,
  output logic          busy_o,
  output logic          done_o,
  output logic          err_o
);

  localparam int          IW        = $clog2(TIMEOUT_CYCLES);
  localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT_CYCLES - 1);
  localparam logic [AW:0] MAX_LEN   = (AW + 1)'(NO_OF_REGS);

  boot_state_e   state;
  boot_outs_t    outs_q;
  logic [AW:0]   word_idx;
  logic [AW:0]   word_idx_inc;
  logic [AW:0]   len_q;
  logic [IW-1:0] idle_cnt;

  logic accept;
  logic last_byte;
  logic start_ok;
  logic len_ok;
  logic timeout;
  logic pack_clear;

  assign accept       = outs_q.byte_ready & byte_valid_i;
  assign start_ok     = start_i &&
                        (state == ST_IDLE || state == ST_RUN || state == ST_ERROR);
  assign len_ok       = (len_i != '0) && (len_i <= MAX_LEN);
  assign timeout      = (state == ST_LOAD) && !accept && (idle_cnt == IDLE_LAST);
  assign pack_clear   = start_ok || timeout;
  assign word_idx_inc = word_idx + (AW + 1)'(1);

  boot_word_packer #(
    .DW (DW)
  ) u_packer (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .clear_i     (pack_clear),
    .accept_i    (accept),
    .byte_i      (byte_i),
    .word_o      (imem_wdata_o),
    .last_byte_o (last_byte)
  );

  // Every transition loads the output vector of the destination state, so
  // outputs change on the same edge as the state and never glitch.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= ST_IDLE;
      outs_q   <= state_outs(ST_IDLE);
      word_idx <= '0;
      len_q    <= '0;
      idle_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_RUN, ST_ERROR: begin
          if (start_i) begin
            word_idx <= '0;
            idle_cnt <= '0;
            if (len_ok) begin
              len_q  <= len_i;
              state  <= ST_LOAD;
              outs_q <= state_outs(ST_LOAD);
            end else begin
              state  <= ST_ERROR;
              outs_q <= state_outs(ST_ERROR);
            end
          end
        end

        ST_LOAD: begin
          if (accept) begin
            idle_cnt <= '0;
            if (last_byte) begin
              state  <= ST_WRITE;
              outs_q <= state_outs(ST_WRITE);
            end
          end else if (timeout) begin
            idle_cnt <= '0;
            state    <= ST_ERROR;
            outs_q   <= state_outs(ST_ERROR);
          end else begin
            idle_cnt <= idle_cnt + IW'(1);
          end
        end

        ST_WRITE: begin
          // len_q never exceeds NO_OF_REGS, so the address stops at NO_OF_REGS-1.
          word_idx <= word_idx_inc;
          idle_cnt <= '0;
          if (word_idx_inc == len_q) begin
            state  <= ST_RUN;
            outs_q <= state_outs(ST_RUN);
          end else begin
            state  <= ST_LOAD;
            outs_q <= state_outs(ST_LOAD);
          end
        end

        default: begin
          state  <= ST_IDLE;
          outs_q <= state_outs(ST_IDLE);
        end
      endcase
    end
  end

  assign byte_ready_o = outs_q.byte_ready;
  assign imem_we_o    = outs_q.imem_we;
  assign imem_addr_o  = word_idx[AW-1:0];
  assign core_rst_o   = outs_q.core_rst;
  assign busy_o       = outs_q.busy;
  assign done_o       = outs_q.done;
  assign err_o        = outs_q.err;

endmodule

// File: tb/tb_riscv_boot_ctrl.sv
// Self-checking bench for riscv_boot_ctrl: directed and randomized image loads
// checked against a byte-stream model of the expected memory writes.
module tb_riscv_boot_ctrl;

  localparam int DW         = 32;
  localparam int NO_OF_REGS = 256;
  localparam int AW         = 8;
  localparam int TIMEOUT    = 1024;

  typedef logic [7:0] byte_q_t[$];

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          start_i = 1'b0;
  logic [AW:0]   len_i = '0;
  logic          byte_valid_i = 1'b0;
  logic [7:0]    byte_i = '0;
  logic          byte_ready_o;
  logic          imem_we_o;
  logic [AW-1:0] imem_addr_o;
  logic [DW-1:0] imem_wdata_o;
  logic          core_rst_o;
  logic          busy_o;
  logic          done_o;
  logic          err_o;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  logic [AW-1:0] wr_addr_q[$];
  logic [DW-1:0] wr_data_q[$];

  riscv_boot_ctrl #(
    .DW             (DW),
    .NO_OF_REGS     (NO_OF_REGS),
    .AW             (AW),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .start_i      (start_i),
    .len_i        (len_i),
    .byte_valid_i (byte_valid_i),
    .byte_i       (byte_i),
    .byte_ready_o (byte_ready_o),
    .imem_we_o    (imem_we_o),
    .imem_addr_o  (imem_addr_o),
    .imem_wdata_o (imem_wdata_o),
    .core_rst_o   (core_rst_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_o        (err_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  always @(negedge clk_i) begin
    if (rst_ni && imem_we_o === 1'b1) begin
      wr_addr_q.push_back(imem_addr_o);
      wr_data_q.push_back(imem_wdata_o);
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic byte_q_t rand_image(input int n_bytes);
    byte_q_t q;
    for (int i = 0; i < n_bytes; i++) q.push_back(8'($urandom_range(0, 255)));
    return q;
  endfunction

  // Word i of the image: byte 4i is least significant.
  function automatic logic [31:0] model_word(input byte_q_t bs, input int i);
    logic [31:0] w;
    w = 0;
    for (int k = 0; k < 4; k++) w = w + (32'(bs[4*i+k]) << (8 * k));
    return w;
  endfunction

  task automatic clear_writes();
    wr_addr_q.delete();
    wr_data_q.delete();
  endtask

  task automatic do_start(input int len);
    @(negedge clk_i);
    start_i = 1'b1;
    len_i   = (AW + 1)'(len);
    @(negedge clk_i);
    start_i = 1'b0;
  endtask

  // Offers bytes from negedge to negedge; returns one negedge after the last accept.
  task automatic send_bytes(input byte_q_t bs, input bit throttle);
    int  sent  = 0;
    int  guard = 0;
    bit  gap   = 1'b0;
    while (sent < bs.size() && guard < 6000) begin
      if (guard > 0) @(negedge clk_i);
      guard++;
      if (throttle && gap) begin
        byte_valid_i = 1'b0;
      end else begin
        byte_valid_i = 1'b1;
        byte_i       = bs[sent];
      end
      if (byte_valid_i && byte_ready_o) sent++;
      gap = throttle ? !gap : 1'b0;
    end
    @(negedge clk_i);
    byte_valid_i = 1'b0;
    check("bytes_accepted", 64'(sent), 64'(bs.size()));
  endtask

  task automatic check_writes(input string tag, input byte_q_t bs, input int len);
    check({tag, "_wr_count"}, 64'(wr_addr_q.size()), 64'(len));
    for (int i = 0; i < len && i < wr_addr_q.size(); i++) begin
      check({tag, "_wr_addr"}, 64'(wr_addr_q[i]), 64'(i));
      check({tag, "_wr_data"}, 64'(wr_data_q[i]), 64'(model_word(bs, i)));
    end
  endtask

  task automatic run_load(input string tag, input int len, input bit throttle, input byte_q_t bs);
    clear_writes();
    do_start(len);
    check({tag, "_start_core_rst"}, 64'(core_rst_o), 64'd1);
    check({tag, "_start_busy"}, 64'(busy_o), 64'd1);
    check({tag, "_start_done"}, 64'(done_o), 64'd0);
    check({tag, "_start_err"}, 64'(err_o), 64'd0);
    send_bytes(bs, throttle);
    // Cycle N+1 after the last accepted byte: the final write.
    check({tag, "_last_we"}, 64'(imem_we_o), 64'd1);
    check({tag, "_last_addr"}, 64'(imem_addr_o), 64'(len - 1));
    check({tag, "_last_ready"}, 64'(byte_ready_o), 64'd0);
    check({tag, "_last_core_rst"}, 64'(core_rst_o), 64'd1);
    @(negedge clk_i);
    check({tag, "_run_core_rst"}, 64'(core_rst_o), 64'd0);
    check({tag, "_run_done"}, 64'(done_o), 64'd1);
    check({tag, "_run_busy"}, 64'(busy_o), 64'd0);
    check({tag, "_run_we"}, 64'(imem_we_o), 64'd0);
    @(negedge clk_i);
    check_writes(tag, bs, len);
  endtask

  initial begin
    byte_q_t img;
    byte_q_t part;
    int      len;

    // Reset values
    #12;
    check("rst_core_rst", 64'(core_rst_o), 64'd1);
    check("rst_ready", 64'(byte_ready_o), 64'd0);
    check("rst_we", 64'(imem_we_o), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_done", 64'(done_o), 64'd0);
    check("rst_err", 64'(err_o), 64'd0);
    check("rst_wdata", 64'(imem_wdata_o), 64'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (2) @(negedge clk_i);
    check("idle_core_rst", 64'(core_rst_o), 64'd1);
    check("idle_ready", 64'(byte_ready_o), 64'd0);

    // Fixed two-word image, back-to-back then throttled (the latter a reload from RUN)
    img = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    run_load("load", 2, 1'b0, img);
    check("load_word0", 64'(model_word(img, 0)), 64'h0000_0013);
    check("load_word1", 64'(model_word(img, 1)), 64'h0010_0093);
    run_load("throttle", 2, 1'b1, img);

    // Randomized images, random throttling
    for (int k = 0; k < 4; k++) begin
      len = $urandom_range(1, 8);
      img = rand_image(4 * len);
      run_load("rand", len, 1'($urandom_range(0, 1)), img);
    end

    // Illegal lengths
    clear_writes();
    do_start(0);
    check("len0_err", 64'(err_o), 64'd1);
    check("len0_core_rst", 64'(core_rst_o), 64'd1);
    check("len0_busy", 64'(busy_o), 64'd0);
    check("len0_done", 64'(done_o), 64'd0);
    do_start(NO_OF_REGS + 1);
    check("len257_err", 64'(err_o), 64'd1);
    check("len257_core_rst", 64'(core_rst_o), 64'd1);
    check("len257_busy", 64'(busy_o), 64'd0);
    repeat (5) @(negedge clk_i);
    check("illegal_no_write", 64'(wr_addr_q.size()), 64'd0);

    // Timeout after a partial word, then recovery from ERROR
    clear_writes();
    do_start(2);
    part = rand_image(3);
    send_bytes(part, 1'b0);
    repeat (TIMEOUT - 10) @(negedge clk_i);
    check("tmo_before_err", 64'(err_o), 64'd0);
    check("tmo_before_busy", 64'(busy_o), 64'd1);
    repeat (20) @(negedge clk_i);
    check("tmo_err", 64'(err_o), 64'd1);
    check("tmo_busy", 64'(busy_o), 64'd0);
    check("tmo_core_rst", 64'(core_rst_o), 64'd1);
    check("tmo_no_write", 64'(wr_addr_q.size()), 64'd0);
    img = rand_image(4);
    run_load("tmo_recover", 1, 1'b0, img);
    check("tmo_recover_err", 64'(err_o), 64'd0);

    // Full-depth image: last write lands at NO_OF_REGS-1
    img = rand_image(4 * NO_OF_REGS);
    run_load("full", NO_OF_REGS, 1'b0, img);

    // Reset in the middle of a load
    clear_writes();
    do_start(3);
    img = rand_image(12);
    part.delete();
    for (int i = 0; i < 5; i++) part.push_back(img[i]);
    send_bytes(part, 1'b0);
    #2;
    rst_ni = 1'b0;
    #1;
    check("mid_rst_core_rst", 64'(core_rst_o), 64'd1);
    check("mid_rst_busy", 64'(busy_o), 64'd0);
    check("mid_rst_ready", 64'(byte_ready_o), 64'd0);
    check("mid_rst_we", 64'(imem_we_o), 64'd0);
    check("mid_rst_wdata", 64'(imem_wdata_o), 64'd0);
    check("mid_rst_addr", 64'(imem_addr_o), 64'd0);
    clear_writes();
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    byte_valid_i = 1'b1;
    byte_i = 8'hA5;
    repeat (20) @(negedge clk_i);
    byte_valid_i = 1'b0;
    check("mid_rst_no_write", 64'(wr_addr_q.size()), 64'd0);
    check("mid_rst_core_held", 64'(core_rst_o), 64'd1);
    check("mid_rst_done", 64'(done_o), 64'd0);

    // Normal load after the aborted one
    len = $urandom_range(1, 4);
    img = rand_image(4 * len);
    run_load("post_rst", len, 1'b1, img);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
